// File: rtl/sha256_block_feeder.sv
// rtl/sha256_block_feeder.sv - SHA-256 message packer, FIPS 180-4 padder and core sequencer
// Optional feature macro: SHA256_FEEDER_BSWAP_EN (byte-reverse s_data on entry for little-endian sources)
module sha256_block_feeder #(
    parameter int LEN_W    = 32,
    parameter int INIT_GAP = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    input  logic [2:0]   s_bytes,
    output logic         core_init,
    output logic [511:0] core_block,
    output logic         core_first_block,
    output logic [255:0] core_prev_digest,
    input  logic         core_digest_valid,
    input  logic [255:0] core_digest,
    output logic         hash_valid,
    output logic [255:0] hash_digest
);

    localparam int GAP_W = (INIT_GAP < 1) ? 1 : $clog2(INIT_GAP + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAD,
        ST_LAUNCH,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [31:0]        words [16];
    logic [LEN_W-1:0]   len;
    logic [4:0]         wi;
    logic [2:0]         last_bytes;
    logic               pad_done;
    logic               len_pending;
    logic               lead_80;
    logic               launch_after_gap;
    logic [GAP_W-1:0]   gap_cnt;

    logic [31:0]        data_in;
    logic [2:0]         bytes_eff;
    logic [31:0]        byte_mask;
    logic               accept;
    logic               gap_done;
    logic [4:0]         pos;
    logic [31:0]        pad_word;
    logic [63:0]        len_field;

    // Input word conditioning: optional byte swap, clamp byte count, mask bytes past the valid ones
    always_comb begin
`ifdef SHA256_FEEDER_BSWAP_EN
        data_in = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
`else
        data_in = s_data;
`endif
        bytes_eff = (s_bytes > 3'd4) ? 3'd4 : s_bytes;
        case (bytes_eff)
            3'd0:    byte_mask = 32'h0000_0000;
            3'd1:    byte_mask = 32'hff00_0000;
            3'd2:    byte_mask = 32'hffff_0000;
            3'd3:    byte_mask = 32'hffff_ff00;
            default: byte_mask = 32'hffff_ffff;
        endcase
        // 0x80 lands in the last data word unless that word was full, then in the following word
        pos = (last_bytes == 3'd4) ? wi : (wi - 5'd1);
        case (last_bytes)
            3'd1:    pad_word = 32'h0080_0000;
            3'd2:    pad_word = 32'h0000_8000;
            3'd3:    pad_word = 32'h0000_0080;
            default: pad_word = 32'h8000_0000;
        endcase
        len_field = 64'(len);
        gap_done  = (gap_cnt == GAP_W'(INIT_GAP - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        core_init  = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: next_state = ST_FILL;
            ST_FILL: begin
                s_ready = 1'b1;
                accept  = s_valid;
                if (s_valid) begin
                    if (s_last) begin
                        next_state = ST_PAD;
                    end else if (wi == 5'd15) begin
                        next_state = ST_LAUNCH;
                    end
                end
            end
            ST_PAD: next_state = ST_LAUNCH;
            ST_LAUNCH: begin
                core_init  = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                core_init = 1'b1;
                if (core_digest_valid) begin
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    next_state = launch_after_gap ? ST_LAUNCH : ST_FILL;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Present the stored words as the big-endian 512-bit block, word 0 on top
    always_comb begin
        core_block = '0;
        for (int i = 0; i < 16; i++) begin
            core_block[511-32*i -: 32] = words[i];
        end
    end

    // Block assembly, padding, length counting, chaining and digest hand-off
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                words[i] <= '0;
            end
            len              <= '0;
            wi               <= '0;
            last_bytes       <= '0;
            pad_done         <= 1'b0;
            len_pending      <= 1'b0;
            lead_80          <= 1'b0;
            launch_after_gap <= 1'b0;
            gap_cnt          <= '0;
            core_first_block <= 1'b1;
            core_prev_digest <= '0;
            hash_valid       <= 1'b0;
            hash_digest      <= '0;
        end else begin
            hash_valid <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        words[wi[3:0]] <= data_in & byte_mask;
                        wi             <= wi + 5'd1;
                        len            <= len + LEN_W'({bytes_eff, 3'b000});
                        last_bytes     <= bytes_eff;
                    end
                end
                ST_PAD: begin
                    if (pos <= 5'd13) begin
                        words[pos[3:0]] <= words[pos[3:0]] | pad_word;
                        words[14]       <= len_field[63:32];
                        words[15]       <= len_field[31:0];
                        pad_done        <= 1'b1;
                    end else if (pos <= 5'd15) begin
                        words[pos[3:0]] <= words[pos[3:0]] | pad_word;
                        len_pending     <= 1'b1;
                    end else begin
                        // Data filled the block exactly: the 0x80 opens the length block
                        len_pending <= 1'b1;
                        lead_80     <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (core_digest_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            words[i] <= '0;
                        end
                        wi               <= '0;
                        core_prev_digest <= core_digest;
                        core_first_block <= 1'b0;
                        if (pad_done) begin
                            hash_digest      <= core_digest;
                            hash_valid       <= 1'b1;
                            len              <= '0;
                            core_prev_digest <= '0;
                            core_first_block <= 1'b1;
                            pad_done         <= 1'b0;
                        end else if (len_pending) begin
                            words[0]         <= lead_80 ? 32'h8000_0000 : 32'h0000_0000;
                            words[14]        <= len_field[63:32];
                            words[15]        <= len_field[31:0];
                            pad_done         <= 1'b1;
                            len_pending      <= 1'b0;
                            lead_80          <= 1'b0;
                            launch_after_gap <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        gap_cnt          <= '0;
                        launch_after_gap <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_feeder.sv
// tb/tb_sha256_block_feeder.sv - scoreboard bench with a behavioural SHA-256 core and reference hash
module tb_sha256_block_feeder;

    localparam int INIT_GAP = 2;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic         s_last = 1'b0;
    logic [2:0]   s_bytes = '0;
    logic         core_init;
    logic [511:0] core_block;
    logic         core_first_block;
    logic [255:0] core_prev_digest;
    logic         core_digest_valid = 1'b0;
    logic [255:0] core_digest = '0;
    logic         hash_valid;
    logic [255:0] hash_digest;

    always #5 clk = ~clk;

    sha256_block_feeder #(.LEN_W(32), .INIT_GAP(INIT_GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_bytes(s_bytes),
        .core_init(core_init), .core_block(core_block), .core_first_block(core_first_block),
        .core_prev_digest(core_prev_digest), .core_digest_valid(core_digest_valid), .core_digest(core_digest),
        .hash_valid(hash_valid), .hash_digest(hash_digest)
    );

    typedef struct {
        logic [255:0] dig;
        int           nblk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Whole-message reference: pad the byte string, then chain compressions
    function automatic logic [255:0] sha_ref(input byte unsigned m[$]);
        byte unsigned p[$];
        logic [63:0]  bits;
        logic [255:0] h;
        logic [511:0] blk;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        h = IV;
        for (int bk = 0; bk < p.size() / 64; bk++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bk+j];
            h = compress(h, blk);
        end
        return h;
    endfunction

    // Behavioural core plus output monitor, sampled 2 time units after each rising edge
    logic         busy = 1'b0;
    int           delay = 0;
    logic [255:0] result = '0;
    logic [255:0] last_result = '0;
    logic [511:0] cap_block = '0;
    logic         prev_init = 1'b0;
    int           msg_blocks = 0;
    int           low_cnt = 0;
    logic         after_reset = 1'b1;
    int           launches = 0;

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (!reset_n) begin
            busy = 1'b0;
            core_digest_valid = 1'b0;
            prev_init = 1'b0;
            msg_blocks = 0;
            low_cnt = 0;
            after_reset = 1'b1;
        end else begin
            if (core_digest_valid) core_digest_valid = 1'b0;
            if (hash_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_hash_valid", 256'(hash_valid), 256'(0));
                end else begin
                    e = sb.pop_front();
                    check("hash_digest", hash_digest, e.dig);
                    check("blocks_per_message", 256'(msg_blocks), 256'(e.nblk));
                end
                msg_blocks = 0;
            end
            if (core_init && s_ready) check("s_ready_while_init", 256'(s_ready), 256'(0));
            if (core_init && !prev_init) begin
                if (!after_reset) check("init_gap", 256'(low_cnt >= INIT_GAP), 256'(1));
                check("first_block", 256'(core_first_block), 256'(msg_blocks == 0));
                check("prev_digest", core_prev_digest, (msg_blocks == 0) ? 256'(0) : last_result);
                cap_block = core_block;
                result = compress((msg_blocks == 0) ? IV : last_result, core_block);
                delay = $urandom_range(70, 200);
                busy = 1'b1;
                msg_blocks++;
                launches++;
                after_reset = 1'b0;
            end else if (busy) begin
                if (!core_init || core_block !== cap_block) begin
                    check("init_held_block_stable", {255'(0), core_init && core_block === cap_block}, 256'(1));
                end
                delay--;
                if (delay == 0) begin
                    core_digest = result;
                    core_digest_valid = 1'b1;
                    last_result = result;
                    busy = 1'b0;
                end
            end
            if (!core_init) low_cnt++;
            else low_cnt = 0;
            prev_init = core_init;
        end
    end

    task automatic drive_word(input logic [31:0] data, input logic [2:0] nbytes, input logic last);
        int guard = 0;
        while (1) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = data;
                s_bytes = nbytes;
                s_last  = last;
                if (s_ready) begin
                    @(posedge clk);
                    break;
                end
            end
            guard++;
            if (guard > 3000) begin
                check("s_ready_timeout", 256'(0), 256'(1));
                break;
            end
        end
    endtask

    task automatic send_msg(input byte unsigned m[$], input bit expect_hash, input bit known,
                            input logic [255:0] kdig);
        exp_t        e;
        int          n;
        int          nw;
        int          nb;
        bit          extra;
        logic [7:0]  bt [4];
        logic [31:0] w;
        n = m.size();
        if (expect_hash) begin
            e.dig  = known ? kdig : sha_ref(m);
            e.nblk = (n + 9 + 63) / 64;
            sb.push_back(e);
        end
        extra = (n % 4 == 0) && (n == 0 || $urandom_range(0, 3) == 0);
        nw = (n + 3) / 4 + (extra ? 1 : 0);
        for (int i = 0; i < nw; i++) begin
            nb = n - 4 * i;
            if (nb > 4) nb = 4;
            if (nb < 0) nb = 0;
            for (int b = 0; b < 4; b++) bt[b] = (b < nb) ? m[4*i+b] : 8'($urandom);
`ifdef SHA256_FEEDER_BSWAP_EN
            w = {bt[3], bt[2], bt[1], bt[0]};
`else
            w = {bt[0], bt[1], bt[2], bt[3]};
`endif
            drive_word(w, 3'(nb), i == nw - 1);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (sb.size() != 0 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", 256'(sb.size()), 256'(0));
    endtask

    initial begin
        byte unsigned m[$];
        string        s;
        int           lens [8] = '{55, 56, 60, 63, 64, 1, 119, 128};
        int           base;
        int           guard;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_s_ready", 256'(s_ready), 256'(0));
        check("reset_core_init", 256'(core_init), 256'(0));
        check("reset_hash_valid", 256'(hash_valid), 256'(0));
        check("reset_first_block", 256'(core_first_block), 256'(1));
        check("reset_prev_digest", core_prev_digest, 256'(0));
        check("reset_hash_digest", hash_digest, 256'(0));
        reset_n = 1'b1;

        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1, 1'b1, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        m = {};
        send_msg(m, 1'b1, 1'b1, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        m = {};
        for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
        send_msg(m, 1'b1, 1'b1, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

        for (int k = 0; k < 14; k++) begin
            int n;
            n = (k < 8) ? lens[k] : $urandom_range(0, 140);
            m = {};
            for (int i = 0; i < n; i++) m.push_back(8'($urandom));
            send_msg(m, 1'b1, 1'b0, '0);
        end
        wait_idle();

        // Abandon a two-block message while its second block is in the core
        m = {};
        for (int i = 0; i < 60; i++) m.push_back(8'($urandom));
        base = launches;
        send_msg(m, 1'b0, 1'b0, '0);
        guard = 0;
        while (launches < base + 2 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("second_launch_seen", 256'(launches - base), 256'(2));
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid_wait_init", 256'(core_init), 256'(0));
        check("reset_mid_wait_hash_valid", 256'(hash_valid), 256'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);

        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1, 1'b1, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        wait_idle();
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
